// File: rtl/dot_prod_engine.sv
// ============================================================================
// dot_prod_engine
// ----------------------------------------------------------------------------
// Purpose:
//   Computes init_acc + sum(a[j] * b[j]) over a wrap-around index window of
//   two internal operand arrays. The arrays are filled through a host load
//   port while the engine is idle. The products go through a 3-stage pipeline:
//   registered read, registered product, then accumulate. The accumulator can
//   either saturate or wrap, and a sticky flag records any signed overflow.
//
// Ports:
//   clk                    in   rising-edge clock for all logic
//   rst                    in   asynchronous active-high reset
//   controlArr             in   load mode (honoured only while idle)
//   controlArrWEnable_a/_b in   array write enables
//   controlArrAddr_a/_b    in   load/readback address (ADDR_W)
//   controlArrWData_a/_b   in   write data (DATA_W)
//   controlArrRData_a/_b   out  registered readback, pre-write contents
//   r_enable               in   start pulse
//   init_i_t_a             in   first index of the window (ADDR_W)
//   len                    in   element count (ADDR_W+1)
//   init_acc_t_a           in   initial accumulator value (ACC_W)
//   sat_en                 in   1 = saturate, 0 = wrap modulo 2^ACC_W
//   busy                   out  job in progress
//   w_enable               out  one-cycle done pulse
//   result                 out  final signed sum, held until the next job ends
//   overflow               out  sticky signed overflow for the current job
// ============================================================================
module dot_prod_engine #(
   parameter int DATA_W = 27,
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1000,
   parameter int ACC_W  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              controlArr,
   input  logic              controlArrWEnable_a,
   input  logic              controlArrWEnable_b,
   input  logic [ADDR_W-1:0] controlArrAddr_a,
   input  logic [ADDR_W-1:0] controlArrAddr_b,
   input  logic [DATA_W-1:0] controlArrWData_a,
   input  logic [DATA_W-1:0] controlArrWData_b,
   output logic [DATA_W-1:0] controlArrRData_a,
   output logic [DATA_W-1:0] controlArrRData_b,
   input  logic              r_enable,
   input  logic [ADDR_W-1:0] init_i_t_a,
   input  logic [ADDR_W:0]   len,
   input  logic [ACC_W-1:0]  init_acc_t_a,
   input  logic              sat_en,
   output logic              busy,
   output logic              w_enable,
   output logic [ACC_W-1:0]  result,
   output logic              overflow
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   localparam int PROD_W = 2 * DATA_W;

   // DEPTH may equal 2^ADDR_W, so address comparisons are done one bit wider.
   localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
   localparam logic [ACC_W-1:0]  ACC_MAX  = {1'b0, {(ACC_W - 1){1'b1}}};
   localparam logic [ACC_W-1:0]  ACC_MIN  = {1'b1, {(ACC_W - 1){1'b0}}};

   state_t state;
   state_t next_state;

   logic [DATA_W-1:0] mem_a [DEPTH];
   logic [DATA_W-1:0] mem_b [DEPTH];

   logic [ADDR_W-1:0] idx;
   logic [ADDR_W:0]   remaining;
   logic              drain_cnt;
   logic              sat_q;

   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              op_valid;
   logic [PROD_W-1:0] prod;
   logic              prod_valid;
   logic [ACC_W-1:0]  acc;

   logic              load_mode;
   logic              start;
   logic              addr_a_ok;
   logic              addr_b_ok;
   logic [ADDR_W-1:0] start_idx;
   logic [ADDR_W-1:0] idx_next;
   logic [PROD_W-1:0] ext_a;
   logic [PROD_W-1:0] ext_b;
   logic [ACC_W:0]    sum;
   logic              sum_ovf;
   logic [ACC_W-1:0]  acc_next;

   // Load mode takes priority over a start request, so a start is only
   // recognised when the host has released the array port.
   assign load_mode = (state == IDLE) && controlArr;
   assign start     = (state == IDLE) && !controlArr && r_enable;
   assign addr_a_ok = {1'b0, controlArrAddr_a} < DEPTH_W;
   assign addr_b_ok = {1'b0, controlArrAddr_b} < DEPTH_W;

   // An out-of-range first index is folded back into the array once at start.
   assign start_idx = ADDR_W'({1'b0, init_i_t_a} % DEPTH_W);
   assign idx_next  = (idx == LAST_IDX) ? '0 : idx + IDX_ONE;

   // Operands are sign-extended to product width so the multiply is a plain
   // full-width product with no width surprises.
   assign ext_a = {{DATA_W{op_a[DATA_W-1]}}, op_a};
   assign ext_b = {{DATA_W{op_b[DATA_W-1]}}, op_b};

   // Accumulate one bit wider than the result; the top two bits disagreeing
   // means the true sum no longer fits in ACC_W signed bits.
   always_comb begin
      sum      = '0;
      sum_ovf  = 1'b0;
      acc_next = '0;
      sum      = {acc[ACC_W-1], acc}
               + {{(ACC_W + 1 - PROD_W){prod[PROD_W-1]}}, prod};
      sum_ovf  = sum[ACC_W] ^ sum[ACC_W-1];
      if (sum_ovf && sat_q) begin
         acc_next = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
         acc_next = sum[ACC_W-1:0];
      end
   end

   // State register for the job sequencer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: RUN issues one index per cycle, and DRAIN waits two
   // cycles for the product and accumulate stages to empty.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = (len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (remaining == CNT_ONE) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_cnt) begin
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Array storage. It is deliberately outside the reset domain, so the
   // contents survive a reset.
   always_ff @(posedge clk) begin
      if (load_mode) begin
         if (controlArrWEnable_a && addr_a_ok) begin
            mem_a[controlArrAddr_a] <= controlArrWData_a;
         end
         if (controlArrWEnable_b && addr_b_ok) begin
            mem_b[controlArrAddr_b] <= controlArrWData_b;
         end
      end
   end

   // Host readback. The read samples the word before any write on the same
   // edge lands, so the host sees the pre-write contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         controlArrRData_a <= '0;
         controlArrRData_b <= '0;
      end else if (load_mode) begin
         controlArrRData_a <= addr_a_ok ? mem_a[controlArrAddr_a] : '0;
         controlArrRData_b <= addr_b_ok ? mem_b[controlArrAddr_b] : '0;
      end
   end

   // Datapath and outputs: index generation, the three pipeline stages, and
   // the job bookkeeping flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx        <= '0;
         remaining  <= '0;
         drain_cnt  <= 1'b0;
         sat_q      <= 1'b0;
         op_a       <= '0;
         op_b       <= '0;
         op_valid   <= 1'b0;
         prod       <= '0;
         prod_valid <= 1'b0;
         acc        <= '0;
         result     <= '0;
         overflow   <= 1'b0;
         busy       <= 1'b0;
         w_enable   <= 1'b0;
      end else begin
         w_enable   <= 1'b0;
         drain_cnt  <= (state == DRAIN) ? ~drain_cnt : 1'b0;

         op_valid   <= (state == RUN);
         if (state == RUN) begin
            op_a      <= mem_a[idx];
            op_b      <= mem_b[idx];
            idx       <= idx_next;
            remaining <= remaining - CNT_ONE;
         end

         prod_valid <= op_valid;
         if (op_valid) begin
            prod <= ext_a * ext_b;
         end

         if (start) begin
            idx       <= start_idx;
            remaining <= len;
            acc       <= init_acc_t_a;
            sat_q     <= sat_en;
            overflow  <= 1'b0;
            busy      <= 1'b1;
         end else if (prod_valid) begin
            acc <= acc_next;
            if (sum_ovf) begin
               overflow <= 1'b1;
            end
         end

         if (state == DONE) begin
            result   <= acc;
            w_enable <= 1'b1;
            busy     <= 1'b0;
         end
      end
   end

endmodule
